// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store size encodings (funct3)
//   - responder FSM state type
//   - latency counter width helper
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Counter only ever holds 0..latency-1; keep at least one bit.
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channel between a datapath and the
// data-memory responder.
//   req_valid/req_ready  request handshake (we, addr, wdata, funct3 payload)
//   rsp_valid/rsp_ready  response handshake (rdata, err payload)
// master = datapath side, slave = memory responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: picks the addressed byte/halfword out of a memory word and
// extends it to 32 bits according to the RV32I load size.
//   word_i    32-bit memory word
//   addr_i    byte offset within the word
//   funct3_i  load size (B/H sign-extend, BU/HU zero-extend, W as-is)
//   data_o    extended load data (0 for encodings that are not loads)
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = word_i >> {addr_i, 3'b000};
    b       = shifted[7:0];
    h       = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{b[7]}}, b};
      F3_BU:   data_o = {24'h0, b};
      F3_H:    data_o = {{16{h[15]}}, h};
      F3_HU:   data_o = {16'h0, h};
      F3_W:    data_o = word_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with fixed response latency.
//   clk, reset  clock and asynchronous active-high reset
//   bus         dmem_responder_if.slave (request in, response out)
// A request is taken in IDLE, waits LATENCY cycles, and is answered in RESP
// until the datapath consumes it. Stores commit on the edge entering RESP so
// that a reset while waiting cancels them. Storage is not reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = cnt_width(LATENCY);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           we_q;
  logic [31:0]    addr_q, wdata_q;
  logic [2:0]     f3_q;
  logic [31:0]    rdata_q;
  logic           err_q;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept, enter_resp;
  logic           cur_we;
  logic [31:0]    cur_addr, cur_wdata;
  logic [2:0]     cur_f3;
  logic           f3_bad, misalign, oor, err;
  logic [AW-1:0]  idx;
  logic [3:0]     be;
  logic [31:0]    wlane, rd_word, ld_data;
  logic           mem_we;

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  // With LATENCY=1 the access resolves on the acceptance edge itself, before
  // the request registers are loaded, so IDLE works off the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_f3    = bus.req_funct3;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = f3_q;
    end
  end

  always_comb begin
    f3_bad   = (cur_f3 inside {3'b011, 3'b110, 3'b111}) || (cur_we && cur_f3[2]);
    misalign = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
               ((cur_f3 == F3_W) && (cur_addr[1:0] != 2'b00));
    oor      = (cur_addr[31:AW+2] != '0);
    err      = f3_bad || misalign || oor;
    idx      = cur_addr[AW+1:2];
  end

  always_comb begin
    case (cur_f3[1:0])
      2'b00:   begin be = 4'b0001 << cur_addr[1:0]; wlane = {4{cur_wdata[7:0]}};  end
      2'b01:   begin be = cur_addr[1] ? 4'b1100 : 4'b0011; wlane = {2{cur_wdata[15:0]}}; end
      default: begin be = 4'b1111; wlane = cur_wdata; end
    endcase
  end

  assign rd_word = mem[idx];

  dmem_load_ext u_ext (
    .word_i   (rd_word),
    .addr_i   (cur_addr[1:0]),
    .funct3_i (cur_f3),
    .data_o   (ld_data)
  );

  // FSM next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cnt_d = '0;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(LATENCY - 1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        f3_q    <= bus.req_funct3;
      end
      if (enter_resp) begin
        err_q   <= err;
        rdata_q <= (err || cur_we) ? 32'h0 : ld_data;
      end
    end
  end

  // Storage has no reset; reset only blocks a commit on the same edge.
  assign mem_we = enter_resp && cur_we && !err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (LATENCY 2 and 1) driven by directed and
// random traffic; a byte-level memory model predicts every response.
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   LAT [2] = '{2, 1};

  logic        rv [2], rwe [2], rrdy [2];
  logic [31:0] radr [2], rwd [2];
  logic [2:0]  rf3 [2];
  logic        o_rdy [2], o_vld [2], o_err [2];
  logic [31:0] o_rd [2];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.req_valid  = rv[0];
  assign bus0.req_we     = rwe[0];
  assign bus0.req_addr   = radr[0];
  assign bus0.req_wdata  = rwd[0];
  assign bus0.req_funct3 = rf3[0];
  assign bus0.rsp_ready  = rrdy[0];
  assign o_rdy[0] = bus0.req_ready;
  assign o_vld[0] = bus0.rsp_valid;
  assign o_rd[0]  = bus0.rsp_rdata;
  assign o_err[0] = bus0.rsp_err;

  assign bus1.req_valid  = rv[1];
  assign bus1.req_we     = rwe[1];
  assign bus1.req_addr   = radr[1];
  assign bus1.req_wdata  = rwd[1];
  assign bus1.req_funct3 = rf3[1];
  assign bus1.rsp_ready  = rrdy[1];
  assign o_rdy[1] = bus1.req_ready;
  assign o_vld[1] = bus1.rsp_valid;
  assign o_rd[1]  = bus1.rsp_rdata;
  assign o_err[1] = bus1.rsp_err;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mm [2][1024];
  bit          m_pend [2], m_vld [2], m_err [2];
  logic [31:0] m_rd [2];
  int          due [2];
  int          ecnt = 0;
  bit          p_we [2];
  logic [2:0]  p_f3 [2];
  logic [31:0] p_a [2], p_wd [2];

  function automatic void resolve(input int d);
    int sz;
    bit e;
    logic [31:0] r, a;
    a = p_a[d];
    case (p_f3[d])
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    e = (sz == 0) || (p_we[d] && p_f3[d] > 3'd2);
    if (!e) e = ((a % sz) != 0) || (a >= 32'd1024);
    r = 32'h0;
    if (!e) begin
      if (p_we[d]) begin
        for (int i = 0; i < sz; i++) mm[d][a + i] = p_wd[d][8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) r[8*i +: 8] = mm[d][a + i];
        if (p_f3[d] == 3'd0)      r = 32'($signed(r[7:0]));
        else if (p_f3[d] == 3'd1) r = 32'($signed(r[15:0]));
      end
    end
    m_err[d] = e;
    m_rd[d]  = r;
    m_vld[d] = 1'b1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin m_pend[d] = 0; m_vld[d] = 0; end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int d = 0; d < 2; d++) begin m_pend[d] = 0; m_vld[d] = 0; end
      end else begin
        ecnt++;
        for (int d = 0; d < 2; d++) begin
          if (m_vld[d]) begin
            if (rrdy[d]) begin m_vld[d] = 0; m_pend[d] = 0; end
          end else if (m_pend[d]) begin
            if (ecnt == due[d]) resolve(d);
          end else if (rv[d]) begin
            m_pend[d] = 1;
            due[d]  = ecnt + LAT[d] - 1;
            p_we[d] = rwe[d];
            p_f3[d] = rf3[d];
            p_a[d]  = radr[d];
            p_wd[d] = rwd[d];
            if (due[d] == ecnt) resolve(d);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          chk($sformatf("rst%0d_ready", d), 32'(o_rdy[d]), 32'd1);
          chk($sformatf("rst%0d_valid", d), 32'(o_vld[d]), 32'd0);
          chk($sformatf("rst%0d_rdata", d), o_rd[d], 32'h0);
          chk($sformatf("rst%0d_err", d),   32'(o_err[d]), 32'd0);
        end else begin
          chk($sformatf("cmp%0d_ready", d), 32'(o_rdy[d]), 32'(!m_pend[d]));
          chk($sformatf("cmp%0d_valid", d), 32'(o_vld[d]), 32'(m_vld[d]));
          if (m_vld[d]) begin
            chk($sformatf("cmp%0d_rdata", d), o_rd[d], m_rd[d]);
            chk($sformatf("cmp%0d_err", d),   32'(o_err[d]), 32'(m_err[d]));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input int d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    bit acc;
    int n, lat;
    rv[d] = 1'b1; rwe[d] = we; rf3[d] = f3; radr[d] = a; rwd[d] = wd; rrdy[d] = 1'b0;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = o_rdy[d];
      @(posedge clk); #1; n++;
    end
    chk($sformatf("accept%0d", d), 32'(acc), 32'd1);
    // Noise while busy; the responder must ignore it.
    rv[d] = 1'($urandom_range(0, 1)); rwe[d] = 1'($urandom_range(0, 1));
    rf3[d] = 3'($urandom_range(0, 7)); radr[d] = $urandom; rwd[d] = $urandom;
    lat = 1;
    while (!o_vld[d] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk($sformatf("latency%0d", d), lat, LAT[d]);
    rd = o_rd[d]; er = o_err[d];
    repeat (hold) begin @(posedge clk); #1; end
    chk($sformatf("hold%0d_rdata", d), o_rd[d], rd);
    chk($sformatf("hold%0d_err", d), 32'(o_err[d]), 32'(er));
    rv[d] = 1'b0; rrdy[d] = 1'b1;
    @(posedge clk); #1;
    rrdy[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    bit acc;
    int n, last, cyc;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; rwe[d] = 0; rrdy[d] = 0; radr[d] = 0; rwd[d] = 0; rf3[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(o_rdy[0]), 32'd1);
    chk("reset_valid", 32'(o_vld[0]), 32'd0);
    reset = 1'b0;

    // define the words random traffic can touch
    for (int w = 0; w < 32; w++)
      for (int d = 0; d < 2; d++) txn(d, 1, 3'd2, 32'(w * 4), $urandom, 0, rd, er);

    // directed sequence on both latencies
    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
      chk("sw_10_err", 32'(er), 32'd0);
      txn(d, 0, 3'd2, 32'h10, 32'h0, 0, rd, er);
      chk("lw_10", rd, 32'hDEADBEEF);
      chk("lw_10_err", 32'(er), 32'd0);
      txn(d, 1, 3'd0, 32'h13, 32'h80, 0, rd, er);
      txn(d, 0, 3'd0, 32'h13, 32'h0, 0, rd, er);
      chk("lb_13", rd, 32'hFFFFFF80);
      txn(d, 0, 3'd4, 32'h13, 32'h0, 0, rd, er);
      chk("lbu_13", rd, 32'h00000080);
      txn(d, 0, 3'd2, 32'h10, 32'h0, 0, rd, er);
      chk("lw_10_merged", rd, 32'h80ADBEEF);
      txn(d, 0, 3'd1, 32'h11, 32'h0, 0, rd, er);
      chk("lh_11_err", 32'(er), 32'd1);
      chk("lh_11_rdata", rd, 32'h0);
      txn(d, 1, 3'd2, 32'h400, 32'h55AA55AA, 0, rd, er);
      chk("sw_400_err", 32'(er), 32'd1);
      chk("sw_400_rdata", rd, 32'h0);
      txn(d, 0, 3'd2, 32'h10, 32'h0, 5, rd, er);
      chk("lw_10_after_err", rd, 32'h80ADBEEF);
      txn(d, 0, 3'd5, 32'h12, 32'h0, 0, rd, er);
      chk("lhu_12", rd, 32'h000080AD);
    end

    // reset while a store waits (LATENCY 2)
    txn(0, 1, 3'd2, 32'h20, 32'hCAFEF00D, 0, rd, er);
    rv[0] = 1; rwe[0] = 1; rf3[0] = 3'd2; radr[0] = 32'h20; rwd[0] = 32'h12345678;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = o_rdy[0];
      @(posedge clk); #1; n++;
    end
    chk("rst_accept", 32'(acc), 32'd1);
    rv[0] = 0;
    reset = 1'b1;
    #1;
    chk("rstw_ready", 32'(o_rdy[0]), 32'd1);
    chk("rstw_valid", 32'(o_vld[0]), 32'd0);
    chk("rstw_rdata", o_rd[0], 32'h0);
    chk("rstw_err", 32'(o_err[0]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    txn(0, 0, 3'd2, 32'h20, 32'h0, 0, rd, er);
    chk("lw_20_kept", rd, 32'hCAFEF00D);

    // back-to-back with rsp_ready tied high
    for (int d = 0; d < 2; d++) begin
      rrdy[d] = 1; last = -1; cyc = 0;
      for (int i = 0; i < 40; i++) begin
        rv[d] = 1; rwe[d] = 1'($urandom_range(0, 1)); rf3[d] = 3'($urandom_range(0, 7));
        radr[d] = 32'($urandom_range(0, 127)); rwd[d] = $urandom;
        @(negedge clk);
        if (o_rdy[d]) begin
          if (last >= 0) chk($sformatf("b2b%0d_spacing", d), cyc - last, LAT[d] + 1);
          last = cyc;
        end
        cyc++;
        @(posedge clk); #1;
      end
      rv[d] = 0;
      repeat (4) begin @(posedge clk); #1; end
      rrdy[d] = 0;
    end

    // random transactions
    for (int i = 0; i < 120; i++) begin
      int d;
      logic [31:0] a;
      d = $urandom_range(0, 1);
      a = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                      : 32'($urandom_range(0, 127));
      txn(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          $urandom_range(0, 3), rd, er);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
